// File: rtl/bank_ticket_pkg.sv
// Shared definitions for the ticket call scheduler: sizes, service codes,
// FSM encoding and the per-desk service preference table.
package bank_ticket_pkg;

  localparam int NUM_DESK = 4;
  localparam int QDEPTH   = 8;
  localparam int TW       = 7;
  localparam int NUM_SVC  = 3;

  localparam logic [2:0] SVC_GEN  = 3'b001;
  localparam logic [2:0] SVC_LOAN = 3'b010;
  localparam logic [2:0] SVC_CUST = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_SERVE = 2'd2
  } sched_state_t;

  // DESK_ORDER[desk][rank] = service index (0 general, 1 loan, 2 customer)
  localparam logic [3:0][2:0][1:0] DESK_ORDER = {
    {2'd1, 2'd2, 2'd0},   // desk3: G, C, L
    {2'd1, 2'd0, 2'd2},   // desk2: C, G, L
    {2'd0, 2'd2, 2'd1},   // desk1: L, C, G
    {2'd2, 2'd1, 2'd0}    // desk0: G, L, C
  };

  function automatic logic [2:0] svc_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/ticket_fifo.sv
// Per-service ticket queue; head is read combinationally so the arbiter can
// latch it in the same cycle it decides which queue to serve.
module ticket_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 7,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally; DEPTH is expected to be a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ticket_call_scheduler.sv
// Issues numbered tickets into three service queues and serves desk calls
// round-robin, each desk draining queues in its own preference order.
module ticket_call_scheduler #(
  parameter int NUM_DESK = bank_ticket_pkg::NUM_DESK,
  parameter int QDEPTH   = bank_ticket_pkg::QDEPTH,
  parameter int TW       = bank_ticket_pkg::TW,
  localparam int CW      = $clog2(QDEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          issue_req,
  output logic                issue_valid,
  output logic [TW-1:0]       issue_ticket,
  output logic                issue_reject,
  input  logic [NUM_DESK-1:0] call_req,
  output logic                call_valid,
  output logic [1:0]          call_desk,
  output logic [TW-1:0]       call_ticket,
  output logic [2:0]          call_service,
  output logic                call_none,
  output logic [CW-1:0]       wait_gen,
  output logic [CW-1:0]       wait_loan,
  output logic [CW-1:0]       wait_cust
);

  import bank_ticket_pkg::*;

  logic [NUM_SVC-1:0] push_vec;
  logic [NUM_SVC-1:0] pop_vec;
  logic [NUM_SVC-1:0] full_vec;
  logic [NUM_SVC-1:0] empty_vec;
  logic [TW-1:0]      head_arr  [NUM_SVC];
  logic [CW-1:0]      count_arr [NUM_SVC];

  logic          issue_onehot;
  logic [1:0]    issue_idx;
  logic          issue_accept;
  logic [TW-1:0] next_ticket_reg;
  logic          issue_valid_reg;
  logic          issue_reject_reg;
  logic [TW-1:0] issue_ticket_reg;

  sched_state_t        state_reg, state_next;
  logic [NUM_DESK-1:0] pending_reg;
  logic [NUM_DESK-1:0] pending_clear;
  logic [1:0]          last_desk_reg;
  logic [1:0]          sel_desk_reg;
  logic [1:0]          sel_svc_reg;
  logic                sel_none_reg;
  logic [1:0]          arb_desk;
  logic [1:0]          arb_svc;
  logic                arb_none;
  logic                desk_found;
  logic [1:0]          cand_desk;
  logic [1:0]          cand_svc;

  logic          call_valid_reg;
  logic [1:0]    call_desk_reg;
  logic [TW-1:0] call_ticket_reg;
  logic [2:0]    call_service_reg;
  logic          call_none_reg;

  // Only clean one-hot requests are accepted; anything else is ignored.
  always_comb begin
    issue_onehot = 1'b0;
    issue_idx    = 2'd0;
    case (issue_req)
      SVC_GEN:  begin issue_onehot = 1'b1; issue_idx = 2'd0; end
      SVC_LOAN: begin issue_onehot = 1'b1; issue_idx = 2'd1; end
      SVC_CUST: begin issue_onehot = 1'b1; issue_idx = 2'd2; end
      default:  ;
    endcase
  end

  // Fullness comes from registered occupancy, so a same-cycle pop never frees a slot.
  assign issue_accept = issue_onehot && !full_vec[issue_idx];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SVC; gi++) begin : g_svc
      assign push_vec[gi] = issue_accept && (issue_idx == 2'(gi));
      assign pop_vec[gi]  = (state_reg == ST_SERVE) && !sel_none_reg &&
                            (sel_svc_reg == 2'(gi));
      ticket_fifo #(
        .DEPTH (QDEPTH),
        .W     (TW)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_vec[gi]),
        .push_data (next_ticket_reg),
        .pop       (pop_vec[gi]),
        .head      (head_arr[gi]),
        .count     (count_arr[gi]),
        .full      (full_vec[gi]),
        .empty     (empty_vec[gi])
      );
    end
    for (gi = 0; gi < NUM_DESK; gi++) begin : g_desk
      assign pending_clear[gi] = (state_reg == ST_SERVE) && (sel_desk_reg == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_ticket_reg  <= TW'(1);
      issue_valid_reg  <= 1'b0;
      issue_reject_reg <= 1'b0;
      issue_ticket_reg <= '0;
    end else begin
      issue_valid_reg  <= issue_accept;
      issue_reject_reg <= issue_onehot && full_vec[issue_idx];
      if (issue_accept) begin
        issue_ticket_reg <= next_ticket_reg;
        next_ticket_reg  <= (next_ticket_reg == '1) ? TW'(1) : next_ticket_reg + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Round-robin desk pick starts just after the last served desk.
  always_comb begin
    state_next = state_reg;
    arb_desk   = last_desk_reg;
    arb_svc    = 2'd0;
    arb_none   = 1'b1;
    desk_found = 1'b0;
    cand_desk  = 2'd0;
    cand_svc   = 2'd0;
    for (int k = 1; k <= NUM_DESK; k++) begin
      cand_desk = 2'((int'(last_desk_reg) + k) % NUM_DESK);
      if (!desk_found && pending_reg[cand_desk]) begin
        desk_found = 1'b1;
        arb_desk   = cand_desk;
      end
    end
    for (int k = 0; k < NUM_SVC; k++) begin
      cand_svc = DESK_ORDER[arb_desk][2'(k)];
      if (arb_none && !empty_vec[cand_svc]) begin
        arb_none = 1'b0;
        arb_svc  = cand_svc;
      end
    end
    case (state_reg)
      ST_IDLE:  if (|pending_reg) state_next = ST_ARB;
      ST_ARB:   state_next = ST_SERVE;
      ST_SERVE: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Call results are latched at the end of ARB so they are visible during SERVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg      <= '0;
      last_desk_reg    <= 2'(NUM_DESK - 1);
      sel_desk_reg     <= 2'd0;
      sel_svc_reg      <= 2'd0;
      sel_none_reg     <= 1'b1;
      call_valid_reg   <= 1'b0;
      call_desk_reg    <= 2'd0;
      call_ticket_reg  <= '0;
      call_service_reg <= 3'b000;
      call_none_reg    <= 1'b0;
    end else begin
      pending_reg    <= (pending_reg | call_req) & ~pending_clear;
      call_valid_reg <= 1'b0;
      if (state_reg == ST_ARB) begin
        sel_desk_reg     <= arb_desk;
        sel_svc_reg      <= arb_svc;
        sel_none_reg     <= arb_none;
        call_valid_reg   <= 1'b1;
        call_desk_reg    <= arb_desk;
        call_none_reg    <= arb_none;
        call_ticket_reg  <= arb_none ? '0 : head_arr[arb_svc];
        call_service_reg <= arb_none ? 3'b000 : svc_onehot(arb_svc);
      end
      if (state_reg == ST_SERVE) last_desk_reg <= sel_desk_reg;
    end
  end

  assign issue_valid  = issue_valid_reg;
  assign issue_reject = issue_reject_reg;
  assign issue_ticket = issue_ticket_reg;
  assign call_valid   = call_valid_reg;
  assign call_desk    = call_desk_reg;
  assign call_ticket  = call_ticket_reg;
  assign call_service = call_service_reg;
  assign call_none    = call_none_reg;
  assign wait_gen     = count_arr[0];
  assign wait_loan    = count_arr[1];
  assign wait_cust    = count_arr[2];

endmodule

// File: tb/tb_ticket_call_scheduler.sv
// Scoreboard bench for ticket_call_scheduler: directed stimulus pushes
// expected results; negedge monitors pop and compare DUT outputs.
module tb_ticket_call_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] issue_req = 3'b000;
  logic [3:0] call_req = 4'b0000;
  logic       issue_valid, issue_reject, call_valid, call_none;
  logic [6:0] issue_ticket, call_ticket;
  logic [1:0] call_desk;
  logic [2:0] call_service;
  logic [3:0] wait_gen, wait_loan, wait_cust;

  typedef struct packed { logic rej; logic [6:0] t; } iss_t;
  typedef struct packed { logic [1:0] d; logic [6:0] t; logic [2:0] s; logic none; } call_t;

  iss_t  iss_q[$];
  call_t call_q[$];
  int    call_times[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  ticket_call_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_req    (issue_req),
    .issue_valid  (issue_valid),
    .issue_ticket (issue_ticket),
    .issue_reject (issue_reject),
    .call_req     (call_req),
    .call_valid   (call_valid),
    .call_desk    (call_desk),
    .call_ticket  (call_ticket),
    .call_service (call_service),
    .call_none    (call_none),
    .wait_gen     (wait_gen),
    .wait_loan    (wait_loan),
    .wait_cust    (wait_cust)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    iss_t  ei;
    call_t ec;
    if (issue_valid || issue_reject) begin
      $display("issue  : valid=%0b reject=%0b ticket=%0d", issue_valid, issue_reject, issue_ticket);
      if (iss_q.size() == 0) chk("issue_unexpected", 1, 0);
      else begin
        ei = iss_q.pop_front();
        chk("issue_reject", int'(issue_reject), int'(ei.rej));
        chk("issue_valid", int'(issue_valid), int'(!ei.rej));
        if (!ei.rej) chk("issue_ticket", int'(issue_ticket), int'(ei.t));
      end
    end
    if (call_valid) begin
      $display("call   : desk=%0d ticket=%0d service=%03b none=%0b",
               call_desk, call_ticket, call_service, call_none);
      call_times.push_back(cyc);
      if (call_q.size() == 0) chk("call_unexpected", 1, 0);
      else begin
        ec = call_q.pop_front();
        chk("call_desk", int'(call_desk), int'(ec.d));
        chk("call_ticket", int'(call_ticket), int'(ec.t));
        chk("call_service", int'(call_service), int'(ec.s));
        chk("call_none", int'(call_none), int'(ec.none));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    issue_req = 3'b000;
    call_req = 4'b0000;
    tick();
    tick();
    iss_q.delete();
    call_q.delete();
    call_times.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while ((iss_q.size() != 0 || call_q.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    chk("sb_drain", iss_q.size() + call_q.size(), 0);
    iss_q.delete();
    call_q.delete();
    tick();
    tick();
  endtask

  task automatic issue(input logic [2:0] s, input logic rej, input logic [6:0] t);
    iss_t e;
    e.rej = rej;
    e.t = t;
    iss_q.push_back(e);
    issue_req = s;
    tick();
    issue_req = 3'b000;
  endtask

  task automatic exp_call(input logic [1:0] d, input logic [6:0] t, input logic [2:0] s, input logic none);
    call_t e;
    e.d = d;
    e.t = t;
    e.s = s;
    e.none = none;
    call_q.push_back(e);
  endtask

  task automatic call(input logic [3:0] mask);
    int c0;
    c0 = cyc;
    call_times.delete();
    call_req = mask;
    tick();
    call_req = 4'b0000;
    drain();
    if (call_times.size() > 0) chk("call_latency", call_times[0] - c0, 3);
    else chk("call_seen", 0, 1);
  endtask

  // Issue lands in the SERVE cycle of the call, i.e. same cycle as the pop.
  task automatic call_with_issue(input logic [3:0] mask, input logic [2:0] s,
                                 input logic rej, input logic [6:0] t);
    call_req = mask;
    tick();
    call_req = 4'b0000;
    tick();
    tick();
    issue(s, rej, t);
    drain();
  endtask

  initial begin
    logic [2:0] s;
    #1;
    tick();
    tick();
    // reset state
    chk("rst_issue_valid", int'(issue_valid), 0);
    chk("rst_issue_reject", int'(issue_reject), 0);
    chk("rst_call_valid", int'(call_valid), 0);
    chk("rst_call_ticket", int'(call_ticket), 0);
    chk("rst_wait_gen", int'(wait_gen), 0);
    chk("rst_wait_cust", int'(wait_cust), 0);
    rst_n = 1'b1;
    tick();

    // G, L, G after reset
    issue(3'b001, 1'b0, 7'd1);
    issue(3'b010, 1'b0, 7'd2);
    issue(3'b001, 1'b0, 7'd3);
    drain();
    chk("wait_gen_034", int'(wait_gen), 2);
    chk("wait_loan_034", int'(wait_loan), 1);
    chk("wait_cust_034", int'(wait_cust), 0);

    // malformed requests are ignored
    issue_req = 3'b011; tick();
    issue_req = 3'b000; tick();
    issue_req = 3'b111; tick();
    issue_req = 3'b000;
    tick();
    tick();
    chk("wait_gen_bad", int'(wait_gen), 2);
    chk("wait_loan_bad", int'(wait_loan), 1);

    // desk1 prefers loan, then falls back to general
    exp_call(2'd1, 7'd2, 3'b010, 1'b0); call(4'b0010);
    exp_call(2'd1, 7'd1, 3'b001, 1'b0); call(4'b0010);
    chk("hold_ticket", int'(call_ticket), 1);
    chk("hold_desk", int'(call_desk), 1);
    exp_call(2'd0, 7'd3, 3'b001, 1'b0); call(4'b0001);
    issue(3'b100, 1'b0, 7'd4);
    drain();
    exp_call(2'd2, 7'd4, 3'b100, 1'b0); call(4'b0100);

    // all empty: none result
    exp_call(2'd2, 7'd0, 3'b000, 1'b1); call(4'b0100);
    repeat (10) tick();
    chk("hold_none", int'(call_none), 1);

    // full general queue
    do_reset();
    for (int i = 1; i <= 8; i++) issue(3'b001, 1'b0, 7'(i));
    issue(3'b001, 1'b1, 7'd0);
    drain();
    chk("wait_gen_full", int'(wait_gen), 8);
    issue(3'b010, 1'b0, 7'd9);
    drain();
    chk("wait_loan_9", int'(wait_loan), 1);
    exp_call(2'd0, 7'd1, 3'b001, 1'b0);
    call_with_issue(4'b0001, 3'b001, 1'b1, 7'd0);
    chk("wait_gen_rejpop", int'(wait_gen), 7);
    exp_call(2'd0, 7'd2, 3'b001, 1'b0);
    call_with_issue(4'b0001, 3'b001, 1'b0, 7'd10);
    chk("wait_gen_net0", int'(wait_gen), 7);

    // four desks at once, customer queue
    do_reset();
    for (int i = 1; i <= 4; i++) issue(3'b100, 1'b0, 7'(i));
    drain();
    for (int d = 0; d < 4; d++) exp_call(2'(d), 7'(d + 1), 3'b100, 1'b0);
    call(4'b1111);
    chk("rr_count", call_times.size(), 4);
    for (int i = 1; i < call_times.size(); i++)
      chk("call_spacing", call_times[i] - call_times[i-1], 3);
    issue(3'b001, 1'b0, 7'd5);
    issue(3'b010, 1'b0, 7'd6);
    drain();
    exp_call(2'd1, 7'd6, 3'b010, 1'b0);
    exp_call(2'd3, 7'd5, 3'b001, 1'b0);
    call(4'b1010);
    chk("wait_all_zero", int'(wait_gen) + int'(wait_loan) + int'(wait_cust), 0);
    chk("hold_service", int'(call_service), 1);

    // 127 tickets with interleaved calls, then wrap
    do_reset();
    for (int i = 1; i <= 127; i++) begin
      s = 3'b001 << (i % 3);
      issue(s, 1'b0, 7'(i));
      exp_call(2'd0, 7'(i), s, 1'b0);
      call(4'b0001);
    end
    issue(3'b001, 1'b0, 7'd1);
    drain();
    chk("wait_gen_wrap", int'(wait_gen), 1);

    // reset during SERVE aborts the call
    call_req = 4'b0001;
    tick();
    call_req = 4'b0000;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("abort_call_valid", int'(call_valid), 0);
    chk("abort_wait_gen", int'(wait_gen), 0);
    chk("abort_wait_loan", int'(wait_loan), 0);
    chk("abort_wait_cust", int'(wait_cust), 0);
    issue(3'b001, 1'b0, 7'd1);
    drain();
    chk("post_abort_gen", int'(wait_gen), 1);

    chk("sb_leftover", iss_q.size() + call_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
